// File: rtl/gsensor_spi_responder_if.sv
// Pin bundle for the G-sensor SPI responder: SPI link, local register port
// and write-notification outputs.
interface gsensor_spi_responder_if;
  logic       SPI_SCLK;
  logic       SPI_CS_N;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       SPI_MISO_OE;
  logic       LOC_WR_EN;
  logic [5:0] LOC_ADDR;
  logic [7:0] LOC_WDATA;
  logic [7:0] LOC_RDATA;
  logic       SPI_WR_STROBE;
  logic [5:0] SPI_WR_ADDR;
  logic [7:0] SPI_WR_DATA;
  logic       BUSY;

  modport master (
    output SPI_SCLK, SPI_CS_N, SPI_MOSI, LOC_WR_EN, LOC_ADDR, LOC_WDATA,
    input  SPI_MISO, SPI_MISO_OE, LOC_RDATA, SPI_WR_STROBE, SPI_WR_ADDR,
           SPI_WR_DATA, BUSY
  );

  modport slave (
    input  SPI_SCLK, SPI_CS_N, SPI_MOSI, LOC_WR_EN, LOC_ADDR, LOC_WDATA,
    output SPI_MISO, SPI_MISO_OE, LOC_RDATA, SPI_WR_STROBE, SPI_WR_ADDR,
           SPI_WR_DATA, BUSY
  );
endinterface

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 slave emulating an ADXL345-style accelerometer: 64x8 register
// file with single/burst SPI access and a local fabric port.
module gsensor_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5
) (
  input logic                     CLK,
  input logic                     RST_BTN_N,
  gsensor_spi_responder_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out;
  logic       rw, mb;
  logic [5:0] addr;
  logic       miso, miso_oe, busy;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] loc_rdata;

  logic [7:0] regs [64];

  logic       byte_done, spi_we, loc_we;
  logic [7:0] in_byte;
  logic [5:0] next_addr, rd_sel;
  logic [7:0] rd_data;

  // Idle values preload the synchronizers so reset release creates no edges.
  always_ff @(posedge CLK) begin
    if (!RST_BTN_N) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPI_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign in_byte   = {shift_in[6:0], mosi_s};
  assign byte_done = (state != ST_IDLE) && sclk_rise && !cs_rise && (bit_cnt == 3'd7);
  assign spi_we    = (state == ST_DATA) && !rw && byte_done && (addr != 6'd0);
  assign next_addr = mb ? addr + 6'd1 : addr;
  assign rd_sel    = (state == ST_CMD) ? in_byte[5:0] : next_addr;
  assign rd_data   = regs[rd_sel];
  // SPI write wins when both ports target the same address in one cycle.
  assign loc_we    = bus.LOC_WR_EN && (bus.LOC_ADDR != 6'd0) &&
                     !(spi_we && (bus.LOC_ADDR == addr));

  always_ff @(posedge CLK) begin
    if (!RST_BTN_N) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rw        <= 1'b0;
      mb        <= 1'b0;
      addr      <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= spi_we;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= in_byte;
      end
      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        busy    <= 1'b0;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              bit_cnt <= '0;
              busy    <= 1'b1;
              miso_oe <= 1'b1;
              miso    <= 1'b0;
              state   <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_in <= in_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= in_byte[7];
                mb    <= in_byte[6];
                addr  <= in_byte[5:0];
                state <= ST_DATA;
                if (in_byte[7]) shift_out <= rd_data;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_in <= in_byte;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr <= next_addr;
                if (rw) shift_out <= rd_data;
              end
            end else if (sclk_fall && rw) begin
              miso      <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_BTN_N) begin
      for (int unsigned i = 0; i < 64; i++) regs[6'(i)] <= '0;
      regs[0]   <= DEVID;
      loc_rdata <= '0;
    end else begin
      loc_rdata <= regs[bus.LOC_ADDR];
      if (spi_we) regs[addr] <= in_byte;
      if (loc_we) regs[bus.LOC_ADDR] <= bus.LOC_WDATA;
    end
  end

  assign bus.SPI_MISO      = miso;
  assign bus.SPI_MISO_OE   = miso_oe;
  assign bus.BUSY          = busy;
  assign bus.SPI_WR_STROBE = wr_strobe;
  assign bus.SPI_WR_ADDR   = wr_addr;
  assign bus.SPI_WR_DATA   = wr_data;
  assign bus.LOC_RDATA     = loc_rdata;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Self-checking bench for gsensor_spi_responder: vector table, corner-case
// sequences and randomized traffic against a register-array model.
module tb_gsensor_spi_responder;
  localparam int unsigned SYNC = 2;
  localparam int HP = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  gsensor_spi_responder_if bus();

  gsensor_spi_responder #(.SYNC_STAGES(SYNC), .DEVID(8'hE5)) dut (
    .CLK(clk), .RST_BTN_N(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [13:0] strobe_q[$];
  always @(negedge clk)
    if (bus.SPI_WR_STROBE === 1'b1) strobe_q.push_back({bus.SPI_WR_ADDR, bus.SPI_WR_DATA});

  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic shift(input logic [7:0] cmd, input int nbits, input int hook_bit,
                       input int hook_dly, input logic [5:0] h_addr, input logic [7:0] h_data);
    for (int i = 0; i < 8; i++) rx_buf[i] = '0;
    @(negedge clk);
    bus.SPI_CS_N = 1'b0;
    repeat (HP) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      bus.SPI_SCLK = 1'b0;
      bus.SPI_MOSI = (b < 8) ? cmd[7-b] : tx_buf[(b-8)/8][7-((b-8)%8)];
      repeat (HP) @(negedge clk);
      if (b >= 8) rx_buf[(b-8)/8] = {rx_buf[(b-8)/8][6:0], bus.SPI_MISO};
      bus.SPI_SCLK = 1'b1;
      if (b == hook_bit) begin
        repeat (hook_dly) @(negedge clk);
        bus.LOC_WR_EN = 1'b1;
        bus.LOC_ADDR  = h_addr;
        bus.LOC_WDATA = h_data;
        @(negedge clk);
        bus.LOC_WR_EN = 1'b0;
        repeat (HP - hook_dly - 1) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
    end
  endtask

  task automatic end_xfer();
    bus.SPI_CS_N = 1'b1;
    repeat (2*HP) @(negedge clk);
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.LOC_WR_EN = 1'b1;
    bus.LOC_ADDR  = a;
    bus.LOC_WDATA = d;
    @(negedge clk);
    bus.LOC_WR_EN = 1'b0;
  endtask

  task automatic loc_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.LOC_ADDR = a;
    @(negedge clk);
    d = bus.LOC_RDATA;
  endtask

  task automatic check_reset_outputs();
    check("rst_miso",   bus.SPI_MISO, 0);
    check("rst_oe",     bus.SPI_MISO_OE, 0);
    check("rst_strobe", bus.SPI_WR_STROBE, 0);
    check("rst_waddr",  bus.SPI_WR_ADDR, 0);
    check("rst_wdata",  bus.SPI_WR_DATA, 0);
    check("rst_rdata",  bus.LOC_RDATA, 0);
    check("rst_busy",   bus.BUSY, 0);
  endtask

  typedef struct {
    logic       rw;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    int         exp_strobes;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] model [64];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [5:0] last_addr, a;
    logic [7:0] last_data;
    logic [13:0] exp_q[$];
    logic [7:0] exp_rd [8];
    logic rw, mb;
    int n;

    bus.SPI_SCLK = 1'b1; bus.SPI_CS_N = 1'b1; bus.SPI_MOSI = 1'b0;
    bus.LOC_WR_EN = 1'b0; bus.LOC_ADDR = '0; bus.LOC_WDATA = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("devid_local", bus.LOC_RDATA, 8'hE5);

    tbl[0] = '{1'b1, 6'h00, 8'h00, 8'hE5, 0};
    tbl[1] = '{1'b0, 6'h2D, 8'h08, 8'h00, 1};
    tbl[2] = '{1'b1, 6'h2D, 8'h00, 8'h08, 0};
    tbl[3] = '{1'b0, 6'h00, 8'h12, 8'h00, 0};
    tbl[4] = '{1'b1, 6'h00, 8'h00, 8'hE5, 0};
    tbl[5] = '{1'b0, 6'h3F, 8'hC3, 8'h00, 1};
    tbl[6] = '{1'b1, 6'h3F, 8'h00, 8'hC3, 0};
    tbl[7] = '{1'b1, 6'h01, 8'h00, 8'h00, 0};
    last_addr = '0;
    last_data = '0;

    for (int i = 0; i < 8; i++) begin
      strobe_q.delete();
      tx_buf[0] = tbl[i].data;
      shift({tbl[i].rw, 1'b0, tbl[i].addr}, 16, -1, 0, '0, '0);
      end_xfer();
      if (tbl[i].rw) begin
        check("tbl_read", rx_buf[0], tbl[i].exp_rd);
      end else begin
        check("tbl_strobes", strobe_q.size(), tbl[i].exp_strobes);
        if (tbl[i].exp_strobes == 1) begin
          last_addr = tbl[i].addr;
          last_data = tbl[i].data;
          if (strobe_q.size() > 0) check("tbl_strobe_val", strobe_q[0], {last_addr, last_data});
        end
        check("tbl_hold_addr", bus.SPI_WR_ADDR, last_addr);
        check("tbl_hold_data", bus.SPI_WR_DATA, last_data);
      end
    end

    for (int k = 0; k < 6; k++) loc_write(6'(8'h32 + k), 8'(8'h11 * (k + 1)));
    shift(8'hF2, 8 + 48, -1, 0, '0, '0);
    end_xfer();
    for (int k = 0; k < 6; k++) check("burst_read", rx_buf[k], 8'(8'h11 * (k + 1)));

    strobe_q.delete();
    tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB;
    shift(8'h7F, 24, -1, 0, '0, '0);
    end_xfer();
    check("bw_strobes", strobe_q.size(), 1);
    loc_read(6'h3F, rd); check("bw_reg3f", rd, 8'hAA);
    loc_read(6'h00, rd); check("bw_reg00", rd, 8'hE5);

    loc_write(6'h05, 8'h5C);
    strobe_q.delete();
    tx_buf[0] = 8'hF0;
    shift(8'h05, 12, -1, 0, '0, '0);
    check("abort_busy_on", bus.BUSY, 1);
    check("abort_oe_on", bus.SPI_MISO_OE, 1);
    bus.SPI_CS_N = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("abort_busy_off", bus.BUSY, 0);
    check("abort_oe_off", bus.SPI_MISO_OE, 0);
    check("abort_miso", bus.SPI_MISO, 0);
    repeat (2*HP) @(negedge clk);
    check("abort_strobes", strobe_q.size(), 0);
    loc_read(6'h05, rd); check("abort_reg05", rd, 8'h5C);

    strobe_q.delete();
    tx_buf[0] = 8'h99;
    shift(8'h10, 16, 15, SYNC, 6'h10, 8'h55);
    end_xfer();
    check("coll_strobes", strobe_q.size(), 1);
    loc_read(6'h10, rd); check("coll_reg10", rd, 8'h99);

    loc_write(6'h33, 8'h5A);
    shift(8'hB3, 16, 11, 1, 6'h33, 8'hA5);
    end_xfer();
    check("snap_byte", rx_buf[0], 8'h5A);
    loc_read(6'h33, rd); check("snap_reg33", rd, 8'hA5);

    bus.LOC_ADDR = 6'h2D;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 64; i++) model[i] = '0;
    model[0] = 8'hE5;

    repeat (40) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 6'($urandom); rd = 8'($urandom);
          loc_write(a, rd);
          if (a != 0) model[a] = rd;
        end
        1: begin
          a = 6'($urandom);
          loc_read(a, rd);
          check("rnd_loc_read", rd, model[a]);
        end
        default: begin
          rw = 1'($urandom); mb = 1'($urandom); a = 6'($urandom);
          if ($urandom_range(0, 3) == 0) a = 6'h3E;
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) tx_buf[k] = 8'($urandom);
          exp_q.delete();
          strobe_q.delete();
          shift({rw, mb, a}, 8 + 8*n, -1, 0, '0, '0);
          end_xfer();
          for (int k = 0; k < n; k++) begin
            if (rw) exp_rd[k] = model[a];
            else if (a != 0) begin
              model[a] = tx_buf[k];
              exp_q.push_back({a, tx_buf[k]});
            end
            if (mb) a = a + 6'd1;
          end
          if (rw) begin
            for (int k = 0; k < n; k++) check("rnd_spi_read", rx_buf[k], exp_rd[k]);
          end else begin
            check("rnd_strobe_cnt", strobe_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < strobe_q.size(); k++)
              check("rnd_strobe_val", strobe_q[k], exp_q[k]);
          end
        end
      endcase
    end

    for (int i = 0; i < 64; i += 7) begin
      loc_read(6'(i), rd);
      check("rnd_final_reg", rd, model[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsensor_spi_responder.md
Name: gsensor_spi_responder

Overview:
SPI mode-3 slave with a 64x8 register file. It is the responder end of the accelerometer SPI link that the Embed system drives as master. It decodes the ADXL345-style command byte (R/W, MB, 6-bit address) and serves single-byte or burst reads and writes. It is used to emulate the G-sensor on ARDUINO_IO and in simulation, and it exposes a local port so fabric logic can load sample registers.

Parameters:
SYNC_STAGES, 2, synchronizer flops on SPI_SCLK/SPI_CS_N/SPI_MOSI (min 2)
DEVID, 8'hE5, fixed read-only value of register 0x00

Ports:
CLK  input  1  system clock, 50 MHz; all logic on rising edge
RST_BTN_N  input  1  synchronous active-low reset
SPI_SCLK  input  1  SPI clock from master, idle high (CPOL=1, CPHA=1)
SPI_CS_N  input  1  chip select, active low
SPI_MOSI  input  1  master-to-slave data, MSB first
SPI_MISO  output  1  slave-to-master data, MSB first
SPI_MISO_OE  output  1  MISO output enable (tri-state control at top level)
LOC_WR_EN  input  1  local write strobe
LOC_ADDR  input  6  local read/write address
LOC_WDATA  input  8  local write data
LOC_RDATA  output  8  local read data, registered
SPI_WR_STROBE  output  1  one-cycle pulse per completed SPI register write
SPI_WR_ADDR  output  6  address of that write
SPI_WR_DATA  output  8  data of that write
BUSY  output  1  high while CS is asserted (synchronized)

Behaviour:
- Reset (RST_BTN_N=0 at a CLK edge): state IDLE; regs[1..63]=0 and regs[0]=DEVID; SPI_MISO=0, SPI_MISO_OE=0, SPI_WR_STROBE=0, SPI_WR_ADDR=0, SPI_WR_DATA=0, LOC_RDATA=0, BUSY=0.
- Reset mid-transfer aborts the transfer. The block stays IDLE until the next synchronized CS_N falling edge.
- Inputs pass through SYNC_STAGES flops. SCLK and CS edges are detected on the synchronized values.
- Edge-to-action latency is SYNC_STAGES+1 CLK cycles.
- Supported SCLK is at most CLK/8, so each SCLK half-period is at least 4 CLK cycles.
- MOSI is sampled on each detected SCLK rising edge.
- MISO is updated on each detected SCLK falling edge.
- States:
  - IDLE: waits for CS falling. Then: bit counter=0, BUSY=1, SPI_MISO_OE=1, SPI_MISO=0, go to CMD.
  - CMD: shifts 8 bits on rising edges. After the 8th bit, latch RW=bit7, MB=bit6, ADDR=bits5:0, then go to DATA.
    - If RW=1, load shift_out = regs[ADDR] in that same cycle (snapshot; later local writes do not tear the byte).
  - DATA, read: each falling edge drives the next bit of shift_out onto SPI_MISO, MSB first; the first data bit appears on the 9th falling edge.
    - At each byte boundary (8th rising edge of the byte): if MB=1, ADDR=ADDR+1 (wraps 63 to 0) and reload from the new address; if MB=0, reload from the same address.
  - DATA, write: 8 rising-edge samples form a byte. The byte is written to regs[ADDR], and SPI_WR_STROBE pulses for 1 cycle with ADDR/data.
    - Exception: if ADDR=0, the write is dropped and there is no strobe.
    - After the byte, ADDR increments if MB=1 (wrap 63 to 0); otherwise it is unchanged.
- CS rising (synchronized) in any state: go to IDLE next cycle, BUSY=0, SPI_MISO_OE=0, SPI_MISO=0. A partial byte is discarded, with no write and no strobe.
- SCLK edges while IDLE are ignored.
- Local port:
  - LOC_WR_EN=1 writes LOC_WDATA to regs[LOC_ADDR] in the same cycle. Writes to address 0 are ignored.
  - An SPI write and a local write to the same address in the same cycle: SPI wins and the local write is dropped.
  - LOC_RDATA = regs[LOC_ADDR] registered, with 1-cycle latency.
  - A write and a read to the same address in the same cycle return the old value.
- SPI_WR_ADDR/SPI_WR_DATA hold their last values between strobes.

Test Plan:
- Reset, then read command 0x80 with one data byte -> MISO shifts 0xE5. LOC_RDATA with LOC_ADDR=0 gives 0xE5 two cycles after reset release. All outputs are 0 during reset.
- Write command 0x2D, data 0x08 -> one SPI_WR_STROBE with ADDR=0x2D, DATA=0x08. Then read command 0xAD returns 0x08.
- Burst read 0xF2 (RW=1, MB=1, addr 0x32) over 6 data bytes, after local loads regs[0x32..0x37]=0x11..0x66 -> MISO gives 0x11,0x22,...,0x66.
- Burst write 0x7F with data 0xAA,0xBB -> regs[0x3F]=0xAA and regs[0x00] stays 0xE5 (wrap to 0, write dropped). Exactly one strobe.
- CS deasserted after 4 data bits of write 0x05 -> no strobe, regs[0x05] unchanged, SPI_MISO_OE=0 and BUSY=0 within SYNC_STAGES+2 cycles.
- Local write 0x55 and SPI write 0x99 to 0x10 in the same cycle -> regs[0x10]=0x99. Separately, a local write to 0x33 in the middle of an SPI read byte from 0x33 -> the byte shifted out is the pre-write value.
